// File: rtl/mcu_pkg.sv
// mcu_pkg: shared encodings for the multi-cycle MIPS control unit.
// Opcodes, function codes, ALU operation codes, mux selects, FSM states and
// the decoded instruction classes used by the decoder and the FSM.
package mcu_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;

  // Write-register-number mux select
  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  // Next-PC mux select
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JR     = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  typedef enum logic [3:0] {
    ST_IF, ST_ID, ST_EXE_A, ST_EXE_B, ST_EXE_LS, ST_MEM, ST_WB_A, ST_WB_L, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_ILLEGAL, CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_BLTZ,
    CL_J, CL_JAL, CL_JR, CL_HALT
  } ins_class_t;

  // Nine states share a 3-bit debug port: both write-back states report 6
  // (DBDataSrc tells them apart) so HALT keeps its own code, 7.
  function automatic logic [2:0] state_code(input state_t s);
    logic [2:0] c;
    case (s)
      ST_IF:     c = 3'd0;
      ST_ID:     c = 3'd1;
      ST_EXE_A:  c = 3'd2;
      ST_EXE_B:  c = 3'd3;
      ST_EXE_LS: c = 3'd4;
      ST_MEM:    c = 3'd5;
      ST_WB_A:   c = 3'd6;
      ST_WB_L:   c = 3'd6;
      ST_HALT:   c = 3'd7;
      default:   c = 3'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// alu_op_decoder: combinational op/func decode into an instruction class,
// ALU operation, operand-A shift select, extension mode and legal flag.
module alu_op_decoder
  import mcu_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic [OPW-1:0]    op,
  input  logic [OPW-1:0]    func,
  output logic [ALUOPW-1:0] alu_op,
  output ins_class_t        ins_class,
  output logic              shamt_sel,
  output logic              ext_sel,
  output logic              legal
);

  logic [2:0] code;

  // Classify the instruction and select its ALU operation
  always_comb begin
    code      = ALU_ADD;
    ins_class = CL_ILLEGAL;
    shamt_sel = 1'b0;
    ext_sel   = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin ins_class = CL_RALU; code = ALU_ADD; end
          FN_SUB: begin ins_class = CL_RALU; code = ALU_SUB; end
          FN_AND: begin ins_class = CL_RALU; code = ALU_AND; end
          FN_OR:  begin ins_class = CL_RALU; code = ALU_OR;  end
          FN_XOR: begin ins_class = CL_RALU; code = ALU_XOR; end
          FN_SLT: begin ins_class = CL_RALU; code = ALU_SLT; end
          FN_SLL: begin ins_class = CL_RALU; code = ALU_SLL; shamt_sel = 1'b1; end
          FN_JR:  ins_class = CL_JR;
          default: ins_class = CL_ILLEGAL;
        endcase
      end
      OP_ADDIU: begin ins_class = CL_IALU; code = ALU_ADD; end
      OP_SLTI:  begin ins_class = CL_IALU; code = ALU_SLT; end
      OP_ANDI:  begin ins_class = CL_IALU; code = ALU_AND; ext_sel = 1'b0; end
      OP_ORI:   begin ins_class = CL_IALU; code = ALU_OR;  ext_sel = 1'b0; end
      OP_XORI:  begin ins_class = CL_IALU; code = ALU_XOR; ext_sel = 1'b0; end
      OP_LW:    begin ins_class = CL_LW;   code = ALU_ADD; end
      OP_SW:    begin ins_class = CL_SW;   code = ALU_ADD; end
      OP_BEQ:   begin ins_class = CL_BEQ;  code = ALU_SUB; end
      OP_BNE:   begin ins_class = CL_BNE;  code = ALU_SUB; end
      OP_BLTZ:  begin ins_class = CL_BLTZ; code = ALU_SUB; end
      OP_J:     ins_class = CL_J;
      OP_JAL:   ins_class = CL_JAL;
      OP_HALT:  ins_class = CL_HALT;
      default:  ins_class = CL_ILLEGAL;
    endcase
  end

  assign alu_op = ALUOPW'(code);
  assign legal  = (ins_class != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB).
// Optional feature macro MCU_ILLEGAL_TRAP_EN: when defined, an undecoded
// instruction raises a sticky illegal flag and halts; otherwise it retires
// as a two-cycle NOP and illegal is tied low.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    op,
  input  logic [OPW-1:0]    func,
  input  logic              zero,
  input  logic              sign,
  output logic              PCWre,
  output logic              IRWre,
  output logic              InsMemRW,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              ExtSel,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              mRD,
  output logic              mWR,
  output logic              DBDataSrc,
  output logic              WrRegDSrc,
  output logic              RegWre,
  output logic [1:0]        RegDst,
  output logic [1:0]        PCSrc,
  output logic              illegal,
  output logic [2:0]        state
);

  state_t            state_reg, state_next;
  ins_class_t        dec_class;
  logic [ALUOPW-1:0] dec_alu_op;
  logic              dec_shamt_sel, dec_ext_sel, dec_legal;
  logic              pc_wre, ir_wre, reg_wre, m_wr;
`ifdef MCU_ILLEGAL_TRAP_EN
  logic              illegal_reg, illegal_next;
`endif

  alu_op_decoder #(.OPW(OPW), .ALUOPW(ALUOPW)) u_dec (
    .op        (op),
    .func      (func),
    .alu_op    (dec_alu_op),
    .ins_class (dec_class),
    .shamt_sel (dec_shamt_sel),
    .ext_sel   (dec_ext_sel),
    .legal     (dec_legal)
  );

  // State register; reset aborts any instruction and restarts at fetch
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_reg <= ST_IF;
    else        state_reg <= state_next;
  end

`ifdef MCU_ILLEGAL_TRAP_EN
  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) illegal_reg <= 1'b0;
    else        illegal_reg <= illegal_next;
  end
  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  // Next-state and per-state control outputs
  always_comb begin
    state_next = state_reg;
`ifdef MCU_ILLEGAL_TRAP_EN
    illegal_next = illegal_reg;
`endif
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    m_wr      = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = '0;
    mRD       = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b0;
    RegDst    = REGDST_RA;
    PCSrc     = PCSRC_SEQ;

    // Datapath steering follows the IR while an instruction is in flight
    if (state_reg != ST_IF && state_reg != ST_HALT) begin
      ALUOp   = dec_alu_op;
      ALUSrcA = dec_shamt_sel;
      ALUSrcB = (dec_class inside {CL_IALU, CL_LW, CL_SW});
      ExtSel  = dec_ext_sel;
    end

    case (state_reg)
      ST_IF: begin
        InsMemRW   = 1'b1;
        ir_wre     = 1'b1;
        state_next = ST_ID;
      end
      ST_ID: begin
        if (!dec_legal) begin
`ifdef MCU_ILLEGAL_TRAP_EN
          illegal_next = 1'b1;
          state_next   = ST_HALT;
`else
          pc_wre     = 1'b1;
          PCSrc      = PCSRC_SEQ;
          state_next = ST_IF;
`endif
        end else begin
          case (dec_class)
            CL_J: begin
              PCSrc      = PCSRC_JUMP;
              pc_wre     = 1'b1;
              state_next = ST_IF;
            end
            CL_JAL: begin
              PCSrc      = PCSRC_JUMP;
              pc_wre     = 1'b1;
              reg_wre    = 1'b1;
              RegDst     = REGDST_RA;
              WrRegDSrc  = 1'b0;
              state_next = ST_IF;
            end
            CL_JR: begin
              PCSrc      = PCSRC_JR;
              pc_wre     = 1'b1;
              state_next = ST_IF;
            end
            CL_BEQ, CL_BNE, CL_BLTZ: state_next = ST_EXE_B;
            CL_LW, CL_SW:            state_next = ST_EXE_LS;
            CL_HALT:                 state_next = ST_HALT;
            default:                 state_next = ST_EXE_A;
          endcase
        end
      end
      ST_EXE_A: state_next = ST_WB_A;
      ST_WB_A: begin
        reg_wre    = 1'b1;
        DBDataSrc  = 1'b0;
        WrRegDSrc  = 1'b1;
        pc_wre     = 1'b1;
        RegDst     = (dec_class == CL_RALU) ? REGDST_RD : REGDST_RT;
        state_next = ST_IF;
      end
      ST_EXE_B: begin
        ALUOp  = ALUOPW'(ALU_SUB);
        pc_wre = 1'b1;
        if ((dec_class == CL_BEQ  &&  zero) ||
            (dec_class == CL_BNE  && !zero) ||
            (dec_class == CL_BLTZ &&  sign))
          PCSrc = PCSRC_BRANCH;
        state_next = ST_IF;
      end
      ST_EXE_LS: state_next = ST_MEM;
      ST_MEM: begin
        if (dec_class == CL_SW) begin
          m_wr       = 1'b1;
          pc_wre     = 1'b1;
          state_next = ST_IF;
        end else begin
          mRD        = 1'b1;
          state_next = ST_WB_L;
        end
      end
      ST_WB_L: begin
        reg_wre    = 1'b1;
        DBDataSrc  = 1'b1;
        WrRegDSrc  = 1'b1;
        RegDst     = REGDST_RT;
        pc_wre     = 1'b1;
        state_next = ST_IF;
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IF;
    endcase
  end

  // Architectural write enables are held off for as long as reset is low
  assign PCWre  = pc_wre  & Reset;
  assign IRWre  = ir_wre  & Reset;
  assign RegWre = reg_wre & Reset;
  assign mWR    = m_wr    & Reset;

  assign state = state_code(state_reg);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction stream checked cycle by
// cycle against a latency/role model of each instruction class.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic       CLK, Reset;
  logic [5:0] op, func;
  logic       zero, sign;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
  logic [2:0] ALUOp;
  logic       mRD, mWR, DBDataSrc, WrRegDSrc, RegWre, illegal;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] state;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .op(op), .func(func), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .RegWre(RegWre),
    .RegDst(RegDst), .PCSrc(PCSrc), .illegal(illegal), .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum int {
    K_RALU, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_BLTZ, K_J, K_JAL, K_JR,
    K_NOP, K_HALT, K_TRAP
  } kind_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    kind_t      kind;
    logic [2:0] alu;
    logic       src_a;
    logic       src_b;
    logic       ext;
  } ins_t;

  ins_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input kind_t kd,
                              input logic [2:0] a, input logic sa, input logic sb, input logic e);
    ins_t r;
    r.op = o; r.fn = f; r.kind = kd; r.alu = a; r.src_a = sa; r.src_b = sb; r.ext = e;
    return r;
  endfunction

  // Observed control word: state, enables, mux selects, illegal
  function automatic logic [15:0] obs_vec();
    return {state, PCWre, IRWre, InsMemRW, RegWre, mWR, mRD, DBDataSrc, WrRegDSrc,
            RegDst, PCSrc, illegal};
  endfunction

  function automatic int latency(input kind_t kd);
    case (kd)
      K_RALU, K_IALU, K_SW:   return 4;
      K_LW:                   return 5;
      K_BEQ, K_BNE, K_BLTZ:   return 3;
      default:                return 2;
    endcase
  endfunction

  // Expected control word for cycle k of an instruction
  function automatic logic [15:0] expect_vec(input ins_t in, input int k, input logic z, input logic s);
    int         n;
    logic       last, pcw, irw, imr, rw, mw, mr, dbs, wrs, taken;
    logic [2:0] st;
    logic [1:0] rd, pcs;
    n = latency(in.kind);
    last = (k == n - 1);
    {pcw, irw, imr, rw, mw, mr, dbs, wrs} = 8'd0;
    rd = 2'b00; pcs = 2'b00;
    taken = (in.kind == K_BEQ && z) || (in.kind == K_BNE && !z) || (in.kind == K_BLTZ && s);
    if (k == 0) st = 3'd0;
    else if (k == 1) st = 3'd1;
    else begin
      case (in.kind)
        K_RALU, K_IALU: st = (k == 2) ? 3'd2 : 3'd6;
        K_LW:           st = (k == 2) ? 3'd4 : ((k == 3) ? 3'd5 : 3'd6);
        K_SW:           st = (k == 2) ? 3'd4 : 3'd5;
        default:        st = 3'd3;
      endcase
    end
    if (k == 0) begin irw = 1'b1; imr = 1'b1; end
    pcw = last && !(in.kind inside {K_HALT, K_TRAP});
    if (last) begin
      case (in.kind)
        K_RALU: begin rw = 1'b1; wrs = 1'b1; rd = 2'b10; end
        K_IALU: begin rw = 1'b1; wrs = 1'b1; rd = 2'b01; end
        K_LW:   begin rw = 1'b1; wrs = 1'b1; dbs = 1'b1; rd = 2'b01; end
        K_SW:   mw = 1'b1;
        K_BEQ, K_BNE, K_BLTZ: pcs = taken ? 2'b01 : 2'b00;
        K_J:    pcs = 2'b11;
        K_JAL:  begin pcs = 2'b11; rw = 1'b1; rd = 2'b00; wrs = 1'b0; end
        K_JR:   pcs = 2'b10;
        default: ;
      endcase
    end
    if (in.kind == K_LW && k == 3) mr = 1'b1;
    return {st, pcw, irw, imr, rw, mw, mr, dbs, wrs, rd, pcs, 1'b0};
  endfunction

  // While reset is held: fetch state, write enables forced off, illegal clear
  function automatic logic [15:0] reset_vec();
    return {3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0};
  endfunction

  // Hold reset one full clock; returns just after an edge with the DUT in fetch
  task automatic do_reset();
    Reset = 1'b0;
    #1;
    check_eq("reset_now", 32'(obs_vec()), 32'(reset_vec()));
    @(posedge CLK); #1;
    check_eq("reset_hold", 32'(obs_vec()), 32'(reset_vec()));
    Reset = 1'b1;
  endtask

  // Runs one instruction from its fetch cycle; abort_at >= 0 resets at that cycle
  task automatic run_instr(input ins_t in, input logic z, input logic s, input int abort_at);
    int         n;
    logic [5:0] f;
    n = latency(in.kind);
    f = (in.op == 6'b000000) ? in.fn : 6'($urandom_range(0, 63));
    op = in.op; func = f; zero = z; sign = s;
    $display("instr op=%b func=%b zero=%b sign=%b cycles=%0d", in.op, f, z, s, n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      check_eq($sformatf("ctl op=%b fn=%b cyc=%0d", in.op, f, k), 32'(obs_vec()), 32'(expect_vec(in, k, z, s)));
      if (k == 2)
        check_eq($sformatf("alu op=%b fn=%b", in.op, f), 32'({ALUOp, ALUSrcA, ALUSrcB, ExtSel}),
                 32'({in.alu, in.src_a, in.src_b, in.ext}));
      if (k == abort_at) begin
        do_reset();
        return;
      end
      @(posedge CLK); #1;
    end
  endtask

  // HALT holds regardless of inputs, with every enable low
  task automatic check_halt(input int cycles, input logic ill);
    for (int c = 0; c < cycles; c++) begin
      op = 6'($urandom_range(0, 63)); func = 6'($urandom_range(0, 63));
      zero = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_eq($sformatf("halt cyc=%0d", c), 32'(obs_vec()), 32'({3'd7, 12'd0, ill}));
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t add_i;
    int   idx;
    Reset = 1'b0; op = '0; func = '0; zero = 1'b0; sign = 1'b0;

    tbl.push_back(mk(6'b000000, 6'b100000, K_RALU, ALU_ADD, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b100010, K_RALU, ALU_SUB, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b100100, K_RALU, ALU_AND, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b100101, K_RALU, ALU_OR,  1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b100110, K_RALU, ALU_XOR, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b101010, K_RALU, ALU_SLT, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b000000, K_RALU, ALU_SLL, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(6'b001001, 6'b000000, K_IALU, ALU_ADD, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(6'b001010, 6'b000000, K_IALU, ALU_SLT, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(6'b001100, 6'b000000, K_IALU, ALU_AND, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(6'b001101, 6'b000000, K_IALU, ALU_OR,  1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(6'b001110, 6'b000000, K_IALU, ALU_XOR, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(6'b100011, 6'b000000, K_LW,   ALU_ADD, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(6'b101011, 6'b000000, K_SW,   ALU_ADD, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(6'b000100, 6'b000000, K_BEQ,  ALU_SUB, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000101, 6'b000000, K_BNE,  ALU_SUB, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000001, 6'b000000, K_BLTZ, ALU_SUB, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000010, 6'b000000, K_J,    ALU_ADD, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000011, 6'b000000, K_JAL,  ALU_ADD, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b001000, K_JR,   ALU_ADD, 1'b0, 1'b0, 1'b1));
`ifndef MCU_ILLEGAL_TRAP_EN
    tbl.push_back(mk(6'b110011, 6'b000000, K_NOP,  ALU_ADD, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(6'b000000, 6'b001111, K_NOP,  ALU_ADD, 1'b0, 1'b0, 1'b1));
`endif

    @(posedge CLK); #1;
    do_reset();

    // Directed: add, add aborted in write-back, then recovery
    add_i = tbl[0];
    run_instr(add_i, 1'b0, 1'b0, -1);
    run_instr(add_i, 1'b0, 1'b0, 3);
    run_instr(add_i, 1'b0, 1'b0, -1);
    run_instr(tbl[12], 1'b0, 1'b0, -1);   // lw
    run_instr(tbl[13], 1'b0, 1'b0, -1);   // sw
    run_instr(tbl[14], 1'b1, 1'b0, -1);   // beq taken
    run_instr(tbl[14], 1'b0, 1'b1, -1);   // beq not taken
    run_instr(tbl[15], 1'b1, 1'b0, -1);   // bne not taken
    run_instr(tbl[15], 1'b0, 1'b0, -1);   // bne taken
    run_instr(tbl[16], 1'b0, 1'b1, -1);   // bltz taken
    run_instr(tbl[16], 1'b1, 1'b0, -1);   // bltz not taken
    run_instr(tbl[18], 1'b0, 1'b0, -1);   // jal
    run_instr(tbl[17], 1'b0, 1'b0, -1);   // j
    run_instr(tbl[19], 1'b0, 1'b0, -1);   // jr
    run_instr(tbl[6],  1'b0, 1'b0, -1);   // sll
    run_instr(tbl[9],  1'b0, 1'b0, -1);   // andi

    // Undecoded opcode 110011
`ifdef MCU_ILLEGAL_TRAP_EN
    run_instr(mk(6'b110011, 6'b000000, K_TRAP, ALU_ADD, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, -1);
    check_halt(10, 1'b1);
    do_reset();
`else
    run_instr(mk(6'b110011, 6'b000000, K_NOP, ALU_ADD, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, -1);
`endif

    // halt, then reset recovery
    run_instr(mk(6'b111111, 6'b000000, K_HALT, ALU_ADD, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, -1);
    check_halt(10, 1'b0);
    do_reset();
    run_instr(add_i, 1'b0, 1'b0, -1);

    // Random instruction stream
    for (int i = 0; i < 250; i++) begin
      idx = $urandom_range(0, tbl.size() - 1);
      run_instr(tbl[idx], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
